apb_master_ctrl: RTL
====================

// Module: apb_master_ctrl
// PURPOSE
//  Parametrised APB3/APB4 requester: takes single-beat requests over a valid/ready port,
//  decodes the address onto one of NSLV PSEL lines, runs SETUP/ACCESS, returns read data and
//  error status. Successor to the two-slave bridge: adds decode, PSTRB, PSLVERR, wait-state timeout,
//  back-to-back transfers. Sits between the CPU load/store path and the peripheral slaves.
// PARAMETERS
//  AW       5    address width (PADDR)
//  DW       32   data width; multiple of 8
//  NSLV     2    slave count, 1..8; slave index = addr[AW-1 -: SW], SW = max(1,$clog2(NSLV))
//  TIMEOUT  16   max ACCESS cycles before abort; 0 disables timeout
// PORTS
//  PCLK       in   1         clock, all flops rise on posedge
//  PRESETn    in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         request accepted when req_valid & req_ready
//  req_write  in   1         1 = write, 0 = read
//  req_addr   in   AW        byte address
//  req_wdata  in   DW        write data
//  req_strb   in   DW/8      write byte strobes (forced 0 on reads)
//  rsp_valid  out  1         one-cycle pulse: transfer finished
//  rsp_rdata  out  DW        read data (0 for writes/errors), valid with rsp_valid
//  rsp_err    out  1         PSLVERR, decode miss or timeout, valid with rsp_valid
//  PSEL       out  NSLV      one-hot slave select
//  PENABLE    out  1         high in ACCESS
//  PWRITE     out  1         direction
//  PADDR      out  AW        address
//  PWDATA     out  DW        write data
//  PSTRB      out  DW/8      byte strobes
//  PREADY     in   NSLV      per-slave ready
//  PRDATA     in   NSLV*DW   per-slave read data, slave i at [i*DW +: DW]
//  PSLVERR    in   NSLV      per-slave error
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (req_ready 0 during reset, 1 in first IDLE cycle after).
//  All APB outputs and rsp_* are registered; held stable from SETUP through ACCESS completion.
//  req_ready = (state==IDLE) | (state==ACCESS & done); done = sel PREADY | timeout.
//  FSM: IDLE -accept-> SETUP (PSEL set, PENABLE=0) -> ACCESS (PENABLE=1).
//   ACCESS: sel PREADY=0 -> stay, wait counter++; done & new accept -> SETUP (no IDLE gap);
//   done & no request -> IDLE, PSEL=0, PENABLE=0.
//  Latency: accept at cycle N -> SETUP N+1 -> ACCESS N+2 -> zero-wait rsp_valid at N+3.
//  Completion: rsp_valid pulses cycle after done; rsp_rdata = PRDATA slice of selected slave on
//   reads without error; rsp_err = PSLVERR of selected slave.
//  Timeout: wait counter reaches TIMEOUT with PREADY low -> abort, rsp_err=1, rdata=0; counter
//   is $clog2(TIMEOUT+1) bits, cleared on entry to ACCESS; never wraps.
//  Decode miss (index >= NSLV): no APB cycle, PSEL stays 0; rsp_valid+rsp_err one cycle after
//   accept; FSM stays IDLE.
//  PREADY/PSLVERR of unselected slaves ignored; PSLVERR sampled only with PREADY.
//  Reset mid-transfer: immediate abort, outputs to reset values, no response emitted.
// STRUCTURE
//  Package apb_pkg: state enum {IDLE,SETUP,ACCESS}, SW function, response struct.
//  Sub-module apb_slave_decode: addr -> one-hot sel + miss flag, and PREADY/PRDATA/PSLVERR mux.
// TESTING
//  Reset: PRESETn=0 -> PSEL=0,PENABLE=0,rsp_valid=0; release -> req_ready=1 next cycle.
//  Write addr 5'h13, data 32'hDEADBEEF, strb 4'hF, NSLV=2 -> PSEL=2'b10, rsp_valid 3 cycles after accept, err=0.
//  Read slave 0 with 2 wait states, PRDATA=32'h0000_00A5 -> ACCESS held 3 cycles, rsp_rdata=32'hA5.
//  Two queued writes -> ACCESS, SETUP, ACCESS with no IDLE between; PENABLE low exactly 1 cycle.
//  PSLVERR=1 with PREADY -> rsp_err=1; PREADY never high, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1.
//  NSLV=3, addr index 3 -> no PSEL, rsp_err=1 one cycle after accept; PRESETn low in ACCESS -> no rsp.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state, response flags and the
// slave-index width helper used by the top and the decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic err;
    } rsp_t;

    // Slave-index width; a single slave still gets one index bit so a miss is decodable.
    function automatic int sw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response port plus APB bus of the requester, bundled as one interface.
// Handshake: a request transfers on a cycle where req_valid & req_ready are both high;
// rsp_valid is a single-cycle pulse carrying rsp_rdata/rsp_err, with no back-pressure.
interface apb_master_ctrl_if #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int NSLV = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_strb;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NSLV-1:0]   PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW/8-1:0]   PSTRB;
    logic [NSLV-1:0]   PREADY;
    logic [NSLV*DW-1:0] PRDATA;
    logic [NSLV-1:0]   PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  PREADY, PRDATA, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output PREADY, PRDATA, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_slave_decode.sv
// Address-index to one-hot select (with miss flag), and the return-path mux that
// picks PREADY/PRDATA/PSLVERR of the currently selected slave.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NSLV = 2,
    parameter int SW   = sw_of(NSLV)
) (
    input  logic [SW-1:0]      idx,
    input  logic [NSLV-1:0]    psel,
    input  logic [NSLV-1:0]    pready,
    input  logic [NSLV*DW-1:0] prdata,
    input  logic [NSLV-1:0]    pslverr,
    output logic [NSLV-1:0]    sel,
    output logic               miss,
    output logic               ready,
    output logic [DW-1:0]      rdata,
    output logic               err
);

    always_comb begin
        sel   = '0;
        miss  = (32'(idx) >= 32'(NSLV));
        ready = 1'b0;
        rdata = '0;
        err   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (32'(idx) == 32'(i)) sel[i] = 1'b1;
            // PSLVERR only counts on the cycle the selected slave is ready.
            if (psel[i]) begin
                ready = ready | pready[i];
                rdata = rdata | prdata[i*DW +: DW];
                err   = err | (pslverr[i] & pready[i]);
            end
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3/APB4 requester: one request at a time through SETUP/ACCESS, address-decoded
// PSEL, PSTRB, error/timeout reporting and back-to-back transfers without an IDLE gap.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int NSLV    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_master_ctrl_if.master bus,
    output state_t            state_dbg
);

    localparam int SW = sw_of(NSLV);
    localparam int SB = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t          state_q, state_d;
    logic            live_q;
    logic [NSLV-1:0] psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [SB-1:0]   pstrb_q, pstrb_d;
    rsp_t            rsp_q, rsp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;

    logic [NSLV-1:0] dec_sel;
    logic            dec_miss;
    logic            sel_ready, sel_err;
    logic [DW-1:0]   sel_rdata;
    logic            timeout_hit, done, req_ready, accept, load;

    apb_slave_decode #(.DW(DW), .NSLV(NSLV), .SW(SW)) u_decode (
        .idx     (bus.req_addr[AW-1 -: SW]),
        .psel    (psel_q),
        .pready  (bus.PREADY),
        .prdata  (bus.PRDATA),
        .pslverr (bus.PSLVERR),
        .sel     (dec_sel),
        .miss    (dec_miss),
        .ready   (sel_ready),
        .rdata   (sel_rdata),
        .err     (sel_err)
    );

    // The count including the current ACCESS cycle reaching TIMEOUT aborts this cycle.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !sel_ready &&
                         ((32'(wcnt_q) + 32'd1) >= 32'(TIMEOUT));
    assign done        = (state_q == ACCESS) && (sel_ready || timeout_hit);
    // A decode miss is not taken while a completion is pending, so two responses never collide.
    assign req_ready   = live_q && ((state_q == IDLE) || (done && !dec_miss));
    assign accept      = bus.req_valid && req_ready;
    assign load        = accept && !dec_miss;

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        wcnt_d    = wcnt_q;
        rsp_d     = '0;
        rdata_d   = '0;
        case (state_q)
            IDLE: begin
                if (accept && dec_miss) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.err   = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wcnt_d    = '0;
            end
            ACCESS: begin
                if (done) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.err   = timeout_hit | sel_err;
                    if (!pwrite_q && !timeout_hit && !sel_err) rdata_d = sel_rdata;
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else if (wcnt_q != CNT_MAX) begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d   = SETUP;
            psel_d    = dec_sel;
            penable_d = 1'b0;
            pwrite_d  = bus.req_write;
            paddr_d   = bus.req_addr;
            pwdata_d  = bus.req_wdata;
            pstrb_d   = bus.req_write ? bus.req_strb : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rsp_q     <= '0;
            rdata_q   <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rsp_q     <= rsp_d;
            rdata_q   <= rdata_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_rdata = rdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign state_dbg     = state_q;

endmodule
